// File: rtl/uart_tx_scheduler_if.sv
// Source/TX-FIFO bundle for uart_tx_scheduler; master drives sources and FIFO status, slave is the scheduler.
interface uart_tx_scheduler_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0]   src_valid;
    logic [8*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]   src_last;
    logic [NUM_SRC-1:0]   src_ready;
    logic                 fifo_full;
    logic                 fifo_write;
    logic [7:0]           fifo_wdata;
    logic [NUM_SRC-1:0]   grant;
    logic                 busy;
    logic                 err_trunc;

    modport master (
        output src_valid, src_data, src_last, fifo_full,
        input  src_ready, fifo_write, fifo_wdata, grant, busy, err_trunc
    );

    modport slave (
        input  src_valid, src_data, src_last, fifo_full,
        output src_ready, fifo_write, fifo_wdata, grant, busy, err_trunc
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin packet scheduler framing {hdr, payload, [csum]} into the UART TX FIFO; one-cycle arbitration,
// payload bytes pass through with zero latency and stall on fifo_full. Macro TX_SCHED_CHECKSUM_EN adds the csum byte.
module uart_tx_scheduler #(
    parameter int NUM_SRC = 4,
    parameter int MAX_LEN = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    uart_tx_scheduler_if.slave  bus
);
    localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW  = $clog2(MAX_LEN + 1);

`ifdef TX_SCHED_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
`endif

    state_t             state_q;
    logic [IDW-1:0]     rr_ptr_q;
    logic [IDW-1:0]     gid_q;
    logic [NUM_SRC-1:0] grant_q;
    logic               busy_q;
    logic               err_trunc_q;
    logic [CW-1:0]      byte_cnt_q;
    logic [7:0]         csum_q;

    logic [IDW-1:0]     pick;
    logic               any_vld;
    logic               g_vld;
    logic               g_last;
    logic [7:0]         g_data;
    logic [7:0]         hdr_byte;
    logic               xfer;
    logic               at_max;
    logic [IDW-1:0]     rr_next;

    // First requester at or above rr_ptr, wrapping at NUM_SRC.
    always_comb begin
        pick    = '0;
        any_vld = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!any_vld && bus.src_valid[idx]) begin
                any_vld = 1'b1;
                pick    = IDW'(idx);
            end
        end
    end

    assign g_vld    = bus.src_valid[gid_q];
    assign g_last   = bus.src_last[gid_q];
    assign g_data   = bus.src_data[{gid_q, 3'b000} +: 8];
    assign hdr_byte = {4'hA, 4'(gid_q)};
    assign at_max   = (byte_cnt_q == CW'(MAX_LEN - 1));
    assign rr_next  = (gid_q == IDW'(NUM_SRC - 1)) ? '0 : gid_q + IDW'(1);

    always_comb begin
        bus.src_ready  = '0;
        bus.fifo_write = 1'b0;
        bus.fifo_wdata = '0;
        xfer           = 1'b0;
        case (state_q)
            HEADER: begin
                if (!bus.fifo_full) begin
                    bus.fifo_write = 1'b1;
                    bus.fifo_wdata = hdr_byte;
                end
            end
            PAYLOAD: begin
                bus.src_ready[gid_q] = !bus.fifo_full;
                xfer = g_vld && !bus.fifo_full;
                if (xfer) begin
                    bus.fifo_write = 1'b1;
                    bus.fifo_wdata = g_data;
                end
            end
`ifdef TX_SCHED_CHECKSUM_EN
            CSUM: begin
                if (!bus.fifo_full) begin
                    bus.fifo_write = 1'b1;
                    bus.fifo_wdata = csum_q;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gid_q       <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            err_trunc_q <= 1'b0;
            byte_cnt_q  <= '0;
            csum_q      <= '0;
        end else begin
            err_trunc_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_vld) begin
                        grant_q <= NUM_SRC'(1) << pick;
                        gid_q   <= pick;
                        busy_q  <= 1'b1;
                        state_q <= HEADER;
                    end
                end
                HEADER: begin
                    if (!bus.fifo_full) begin
                        csum_q  <= hdr_byte;
                        state_q <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        csum_q     <= csum_q ^ g_data;
                        byte_cnt_q <= byte_cnt_q + CW'(1);
                        if (g_last || at_max) begin
                            // A cut packet leaves the source's tail to re-arbitrate later.
                            byte_cnt_q  <= '0;
                            err_trunc_q <= !g_last;
`ifdef TX_SCHED_CHECKSUM_EN
                            state_q     <= CSUM;
`else
                            rr_ptr_q    <= rr_next;
                            grant_q     <= '0;
                            busy_q      <= 1'b0;
                            state_q     <= IDLE;
`endif
                        end
                    end
                end
`ifdef TX_SCHED_CHECKSUM_EN
                CSUM: begin
                    if (!bus.fifo_full) begin
                        rr_ptr_q <= rr_next;
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.err_trunc = err_trunc_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: per-source byte streams are framed by a queue-based reference model; a negedge monitor checks the FIFO side.
module tb_uart_tx_scheduler;
    localparam int NUM_SRC = 4;
    localparam int MAX_LEN = 4;

    typedef logic [8:0] bq_t[$];
    typedef struct packed {
        logic [3:0] id;
        logic       trunc;
    } pkt_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.NUM_SRC(NUM_SRC)) bus ();
    uart_tx_scheduler #(.NUM_SRC(NUM_SRC), .MAX_LEN(MAX_LEN)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    bq_t        src_q[NUM_SRC];
    bq_t        stg[NUM_SRC];
    logic [7:0] exp_q[$];
    pkt_t       pkt_q[$];
    int         mptr = 0;

    logic               chk_en = 1'b0;
    logic               force_full = 1'b0;
    logic               rand_full = 1'b0;
    logic [NUM_SRC-1:0] drop_en = '0;
    logic [NUM_SRC-1:0] prev_grant = '0;
    logic               have_pend = 1'b0;
    logic               pend_trunc = 1'b0;
    int                 trunc_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference framing: round-robin over non-empty streams, cut at last or MAX_LEN.
    task automatic commit();
        bq_t        m[NUM_SRC];
        int         sel;
        int         n;
        logic       any;
        logic       done;
        logic       tr;
        logic [7:0] cs;
        logic [8:0] e;
        for (int i = 0; i < NUM_SRC; i++) begin
            m[i] = stg[i];
            foreach (stg[i][j]) src_q[i].push_back(stg[i][j]);
            stg[i].delete();
        end
        forever begin
            any = 1'b0;
            sel = 0;
            for (int k = 0; k < NUM_SRC; k++) begin
                int idx;
                idx = (mptr + k) % NUM_SRC;
                if (!any && m[idx].size() != 0) begin
                    any = 1'b1;
                    sel = idx;
                end
            end
            if (!any) break;
            cs = 8'hA0 | 8'(sel);
            exp_q.push_back(cs);
            n = 0;
            done = 1'b0;
            tr = 1'b0;
            while (!done) begin
                e = m[sel].pop_front();
                exp_q.push_back(e[7:0]);
                cs = cs ^ e[7:0];
                n++;
                if (e[8]) done = 1'b1;
                else if (n == MAX_LEN) begin
                    done = 1'b1;
                    tr = 1'b1;
                end
            end
`ifdef TX_SCHED_CHECKSUM_EN
            exp_q.push_back(cs);
`endif
            pkt_q.push_back({4'(sel), tr});
            mptr = (sel + 1) % NUM_SRC;
        end
    endtask

    task automatic add_byte(input int s, input logic [7:0] b, input logic last);
        stg[s].push_back({last, b});
    endtask

    task automatic add_pkt(input int s, input int len);
        for (int j = 0; j < len; j++) add_byte(s, 8'($urandom), j == len - 1);
    endtask

    function automatic logic srcs_empty();
        logic r;
        r = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) if (src_q[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic flush();
        if (have_pend) chk("trunc_pulses", trunc_cnt, 32'(pend_trunc));
        have_pend = 1'b0;
        trunc_cnt = 0;
        chk("pkts_left", pkt_q.size(), 0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !srcs_empty() || bus.busy) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 32'(t < 4000), 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        flush();
    endtask

    task automatic wait_writes(input int n, input string nm);
        int seen;
        int t;
        seen = 0;
        t = 0;
        while (seen < n && t < 500) begin
            @(negedge clk);
            if (bus.fifo_write) seen++;
            t++;
        end
        chk(nm, seen, n);
    endtask

    task automatic drive();
        logic [NUM_SRC-1:0]   v;
        logic [NUM_SRC-1:0]   l;
        logic [8*NUM_SRC-1:0] d;
        logic [8:0]           e;
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_q[i].size() != 0 && !(drop_en[i] && $urandom_range(0, 3) == 0)) begin
                e = src_q[i][0];
                v[i] = 1'b1;
                l[i] = e[8];
                d[i*8 +: 8] = e[7:0];
            end
        end
        bus.src_valid = v;
        bus.src_last  = l;
        bus.src_data  = d;
        bus.fifo_full = force_full | (rand_full && ($urandom_range(0, 2) == 0));
    endtask

    // Source driver: pops bytes the DUT accepted, then presents the next ones.
    initial begin
        logic [NUM_SRC-1:0] acc;
        bus.src_valid = '0;
        bus.src_last  = '0;
        bus.src_data  = '0;
        bus.fifo_full = 1'b0;
        forever begin
            @(negedge clk);
            acc = bus.src_valid & bus.src_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_SRC; i++) if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            drive();
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            if (bus.fifo_write) begin
                chk("write_while_full", 32'(bus.fifo_full), 0);
                if (exp_q.size() == 0) chk("unexpected_byte", 32'(bus.fifo_wdata), 32'h100);
                else chk("fifo_byte", 32'(bus.fifo_wdata), 32'(exp_q.pop_front()));
            end
            chk("ready_not_granted", 32'(bus.src_ready & ~bus.grant), 0);
            if (bus.fifo_full) chk("ready_while_full", 32'(bus.src_ready), 0);
            chk("busy_vs_grant", 32'(bus.busy), 32'(|bus.grant));
            chk("grant_onehot", 32'($countones(bus.grant) <= 1), 1);
            if (bus.err_trunc) trunc_cnt++;
            if (prev_grant == '0 && bus.grant != '0) begin
                pkt_t p;
                if (have_pend) chk("trunc_pulses", trunc_cnt, 32'(pend_trunc));
                if (pkt_q.size() == 0) begin
                    chk("unexpected_grant", 32'(bus.grant), 0);
                    have_pend = 1'b0;
                end else begin
                    p = pkt_q.pop_front();
                    chk("grant_owner", 32'(bus.grant), 32'(1) << p.id);
                    pend_trunc = p.trunc;
                    have_pend = 1'b1;
                end
                trunc_cnt = 0;
            end
            prev_grant = bus.grant;
        end
    end

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_grant"}, 32'(bus.grant), 0);
        chk({nm, "_busy"}, 32'(bus.busy), 0);
        chk({nm, "_err_trunc"}, 32'(bus.err_trunc), 0);
        chk({nm, "_fifo_write"}, 32'(bus.fifo_write), 0);
        chk({nm, "_src_ready"}, 32'(bus.src_ready), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // Single request from src1.
        add_byte(1, 8'h11, 1'b0);
        add_byte(1, 8'h22, 1'b1);
        commit();
        wait_idle();

        // Two sources streaming 1-byte packets must alternate.
        for (int j = 0; j < 3; j++) begin
            add_pkt(0, 1);
            add_pkt(2, 1);
        end
        commit();
        wait_idle();

        // Backpressure in HEADER, then in PAYLOAD.
        @(negedge clk);
        force_full = 1'b1;
        add_pkt(3, 3);
        commit();
        repeat (5) @(negedge clk);
        force_full = 1'b0;
        wait_writes(1, "bp_header");
        force_full = 1'b1;
        repeat (3) @(negedge clk);
        force_full = 1'b0;
        wait_idle();

        // Truncation: 6 bytes against MAX_LEN=4.
        add_pkt(3, 6);
        commit();
        wait_idle();

        // Random multi-source traffic with random FIFO backpressure.
        rand_full = 1'b1;
        for (int b = 0; b < 25; b++) begin
            logic [NUM_SRC-1:0] msk;
            msk = NUM_SRC'($urandom_range(1, (1 << NUM_SRC) - 1));
            for (int i = 0; i < NUM_SRC; i++)
                if (msk[i]) for (int p = 0; p < int'($urandom_range(1, 2)); p++) add_pkt(i, $urandom_range(1, 6));
            commit();
            wait_idle();
        end

        // Lone source stalling mid-packet by dropping valid.
        drop_en = NUM_SRC'(1);
        for (int p = 0; p < 4; p++) add_pkt(0, $urandom_range(1, 6));
        commit();
        wait_idle();
        drop_en = '0;
        rand_full = 1'b0;

        // Reset asserted after the 2nd payload byte.
        chk_en = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 6; j++) src_q[1].push_back({j == 5, 8'(8'h30 + j)});
        wait_writes(3, "rst_pre_writes");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
        exp_q.delete();
        pkt_q.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_fifo_write", 32'(bus.fifo_write), 0);
        end
        rst_n = 1'b1;
        mptr = 0;
        prev_grant = '0;
        have_pend = 1'b0;
        trunc_cnt = 0;
        chk_en = 1'b1;

        // First arbitration after reset starts from src0: src2 before src3.
        add_pkt(3, 2);
        add_pkt(2, 2);
        commit();
        wait_idle();

        // Wrap: rr_ptr moved to 3, then src1 and src3 compete.
        add_pkt(2, 1);
        commit();
        wait_idle();
        add_pkt(1, 2);
        add_pkt(3, 1);
        add_pkt(3, 2);
        commit();
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
